bss_message_assembler: RTL and testbench

Clocked, parametrised byte-stream capture block for BSS messages. It accepts a valid/ready byte stream and assembles it into a command byte plus address, SV and data fields, each a parametrised number of bytes. Completed messages go to a registered output slot with a valid/ready handshake. It sits between the byte-level deframer (unescape/STX-ETX stripping) and the message decoder, and replaces strobe-per-field capture with a single sequenced port.

---
 rtl/bss_pkg.sv | 23 ++
 rtl/bss_message_assembler_checksum.sv | 33 +++
 rtl/bss_message_assembler.sv | 133 +++++++++++++
 tb/tb_bss_message_assembler.sv | 331 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bss_pkg.sv
// Shared types and constants for the BSS message assembler.
// The CHECK state exists only when BSS_CHECKSUM_EN is defined.
package bss_pkg;

   localparam int BSS_ADDR_BYTES = 6;
   localparam int BSS_SV_BYTES   = 2;
   localparam int BSS_DATA_BYTES = 4;

   localparam logic [7:0] CMD_SET_SV         = 8'h88;
   localparam logic [7:0] CMD_SUBSCRIBE_SV   = 8'h89;
   localparam logic [7:0] CMD_UNSUBSCRIBE_SV = 8'h8A;
   localparam logic [7:0] CMD_SET_SV_PERCENT = 8'h8D;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_CAPTURE
`ifdef BSS_CHECKSUM_EN
      ,
      ST_CHECK
`endif
   } bss_state_e;

endpackage

// File: rtl/bss_message_assembler_checksum.sv
// Running XOR of message bytes; clr_i restarts the sum from the current byte.
// Compiled only when BSS_CHECKSUM_EN is defined.
`ifdef BSS_CHECKSUM_EN
module bss_checksum (
   input  logic       clk_i,
   input  logic       rst_ni,
   input  logic       clr_i,
   input  logic       en_i,
   input  logic [7:0] data_i,
   output logic [7:0] sum_o
);

   logic [7:0] acc_q, acc_d;

   always_comb begin
      acc_d = acc_q;
      if (clr_i)
         acc_d = en_i ? data_i : 8'h00;
      else if (en_i)
         acc_d = acc_q ^ data_i;
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni)
         acc_q <= 8'h00;
      else
         acc_q <= acc_d;
   end

   assign sum_o = acc_q;

endmodule
`endif

// File: rtl/bss_message_assembler.sv
// Assembles a valid/ready byte stream into command/address/sv/data fields
// and publishes them through a one-deep output slot. Optional: BSS_CHECKSUM_EN.
module bss_message_assembler
   import bss_pkg::*;
#(
   parameter int ADDR_BYTES = BSS_ADDR_BYTES,
   parameter int SV_BYTES   = BSS_SV_BYTES,
   parameter int DATA_BYTES = BSS_DATA_BYTES
) (
   input  logic                    clk,
   input  logic                    reset_n,
   input  logic [7:0]              in_data,
   input  logic                    in_valid,
   input  logic                    in_start,
   output logic                    in_ready,
   output logic [7:0]              command,
   output logic [ADDR_BYTES*8-1:0] address,
   output logic [SV_BYTES*8-1:0]   sv,
   output logic [DATA_BYTES*8-1:0] data,
   output logic                    msg_valid,
   input  logic                    msg_ready,
   output logic                    frame_error,
   output logic                    checksum_error
);

   localparam int MSG_BYTES = 1 + ADDR_BYTES + SV_BYTES + DATA_BYTES;
   localparam int CNT_W     = $clog2(MSG_BYTES + 1);
   localparam int SV_IDX    = 1 + ADDR_BYTES;
   localparam int DATA_IDX  = SV_IDX + SV_BYTES;
   localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(MSG_BYTES - 1);

   // Byte 0 is the command; ascending index keeps the first byte in the MSB.
   typedef logic [0:MSG_BYTES-1][7:0] msg_t;

   bss_state_e       state_q;
   logic [CNT_W-1:0] cnt_q;
   msg_t             shadow_q, out_q, msg_d;
   logic             msg_valid_q, frame_error_q, checksum_error_q;
   logic             xfer, completing, cks_ok, publish;

`ifdef BSS_CHECKSUM_EN
   logic [7:0] cks_sum;

   bss_checksum u_checksum (
      .clk_i  (clk),
      .rst_ni (reset_n),
      .clr_i  (xfer && in_start),
      .en_i   (xfer && (in_start || state_q == ST_CAPTURE)),
      .data_i (in_data),
      .sum_o  (cks_sum)
   );

   assign completing = (state_q == ST_CHECK);
   assign cks_ok     = (in_data == cks_sum);
`else
   assign completing = (state_q == ST_CAPTURE) && (cnt_q == LAST_IDX);
   assign cks_ok     = 1'b1;
`endif

   // Only the byte that would publish waits for a free slot.
   assign in_ready = reset_n && !(completing && msg_valid_q && !msg_ready);
   assign xfer     = in_valid && in_ready;
   assign publish  = xfer && !in_start && completing && cks_ok;

   always_comb begin
      msg_d = shadow_q;
      for (int i = 1; i < MSG_BYTES; i++)
         if (cnt_q == CNT_W'(i))
            msg_d[i] = in_data;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q          <= ST_IDLE;
         cnt_q            <= '0;
         shadow_q         <= '0;
         out_q            <= '0;
         msg_valid_q      <= 1'b0;
         frame_error_q    <= 1'b0;
         checksum_error_q <= 1'b0;
      end else begin
         frame_error_q    <= 1'b0;
         checksum_error_q <= 1'b0;
         if (msg_ready)
            msg_valid_q <= 1'b0;
         if (publish) begin
            out_q       <= msg_d;
            msg_valid_q <= 1'b1;
         end
         if (xfer && in_start) begin
            frame_error_q <= (state_q != ST_IDLE);
            shadow_q      <= '0;
            shadow_q[0]   <= in_data;
            cnt_q         <= CNT_W'(1);
            state_q       <= ST_CAPTURE;
         end else if (xfer) begin
            case (state_q)
               ST_CAPTURE: begin
                  shadow_q <= msg_d;
                  if (cnt_q == LAST_IDX) begin
`ifdef BSS_CHECKSUM_EN
                     cnt_q   <= cnt_q + CNT_W'(1);
                     state_q <= ST_CHECK;
`else
                     cnt_q   <= '0;
                     state_q <= ST_IDLE;
`endif
                  end else begin
                     cnt_q <= cnt_q + CNT_W'(1);
                  end
               end
`ifdef BSS_CHECKSUM_EN
               ST_CHECK: begin
                  checksum_error_q <= !cks_ok;
                  cnt_q            <= '0;
                  state_q          <= ST_IDLE;
               end
`endif
               default: ;
            endcase
         end
      end
   end

   assign command        = out_q[0];
   assign address        = out_q[1 +: ADDR_BYTES];
   assign sv             = out_q[SV_IDX +: SV_BYTES];
   assign data           = out_q[DATA_IDX +: DATA_BYTES];
   assign msg_valid      = msg_valid_q;
   assign frame_error    = frame_error_q;
   assign checksum_error = checksum_error_q;

endmodule

// File: tb/tb_bss_message_assembler.sv
// Self-checking bench for bss_message_assembler (default 6/2/4 field sizes).
module tb_bss_message_assembler;
   import bss_pkg::*;

   localparam int MSG  = 13;
   localparam int MSGW = MSG * 8;
`ifdef BSS_CHECKSUM_EN
   localparam int CHK = 1;
`else
   localparam int CHK = 0;
`endif
   localparam int SLEN = MSG + CHK;

   logic        clk = 1'b0;
   logic        reset_n;
   logic [7:0]  in_data;
   logic        in_valid, in_start, in_ready;
   logic [7:0]  command;
   logic [47:0] address;
   logic [15:0] sv;
   logic [31:0] data;
   logic        msg_valid, msg_ready, frame_error, checksum_error;
   logic [MSGW-1:0] out_msg;

   bss_message_assembler dut (
      .clk            (clk),
      .reset_n        (reset_n),
      .in_data        (in_data),
      .in_valid       (in_valid),
      .in_start       (in_start),
      .in_ready       (in_ready),
      .command        (command),
      .address        (address),
      .sv             (sv),
      .data           (data),
      .msg_valid      (msg_valid),
      .msg_ready      (msg_ready),
      .frame_error    (frame_error),
      .checksum_error (checksum_error)
   );

   always #5 clk = ~clk;
   assign out_msg = {command, address, sv, data};

   int total = 0;
   int bad   = 0;

   task automatic chk(input string name, input logic [MSGW-1:0] act, input logic [MSGW-1:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   // Stream byte i of a message; index MSG is the XOR checksum byte.
   function automatic logic [7:0] byte_of(input logic [MSGW-1:0] m, input int i);
      logic [7:0] x;
      x = 8'h00;
      if (i < MSG) return m[MSGW-1-8*i -: 8];
      for (int k = 0; k < MSG; k++) x ^= m[MSGW-1-8*k -: 8];
      return x;
   endfunction

   function automatic logic [MSGW-1:0] rand_msg(input logic [7:0] cmd);
      return {cmd, 16'($urandom), 32'($urandom), 16'($urandom), 32'($urandom)};
   endfunction

   // Reference model: frame bytes collected per the protocol rules.
   logic [7:0]      frame[$];
   logic [MSGW-1:0] expq[$];
   bit              active, in_check, fe_exp, ce_exp, compl, busy;

   function automatic logic [MSGW-1:0] frame_msg();
      logic [MSGW-1:0] m;
      m = '0;
      for (int k = 0; k < MSG; k++) m[MSGW-1-8*k -: 8] = frame[k];
      return m;
   endfunction

   function automatic logic [7:0] frame_xor();
      logic [7:0] x;
      x = 8'h00;
      foreach (frame[k]) x ^= frame[k];
      return x;
   endfunction

   always @(negedge clk) begin
      if (!reset_n) begin
         frame.delete();
         expq.delete();
         active = 0; in_check = 0; fe_exp = 0; ce_exp = 0;
      end else begin
         compl = (CHK != 0) ? in_check : (active && frame.size() == MSG - 1);
         busy  = (expq.size() != 0) && !msg_ready;
         chk("mdl_in_ready", in_ready, !(compl && busy));
         chk("mdl_msg_valid", msg_valid, expq.size() != 0);
         if (expq.size() != 0) chk("mdl_fields", out_msg, expq[0]);
         chk("mdl_frame_error", frame_error, fe_exp);
         chk("mdl_checksum_error", checksum_error, ce_exp);
         fe_exp = 0;
         ce_exp = 0;
         if (msg_valid && msg_ready && expq.size() != 0) void'(expq.pop_front());
         if (in_valid && in_ready) begin
            if (in_start) begin
               fe_exp = active;
               frame.delete();
               frame.push_back(in_data);
               active   = 1;
               in_check = 0;
            end else if (active) begin
               if (in_check) begin
                  if (in_data == frame_xor()) expq.push_back(frame_msg());
                  else ce_exp = 1;
                  active   = 0;
                  in_check = 0;
               end else begin
                  frame.push_back(in_data);
                  if (frame.size() == MSG) begin
                     if (CHK != 0) in_check = 1;
                     else begin
                        expq.push_back(frame_msg());
                        active = 0;
                     end
                  end
               end
            end
         end
      end
   end

   typedef struct {
      logic            vld;
      logic            st;
      logic [7:0]      d;
      logic            exp_mv;
      logic            exp_fe;
      logic [MSGW-1:0] exp_msg;
   } vec_t;
   vec_t vecs[$];

   task automatic add_vec(input logic vld, input logic st, input logic [7:0] d,
                          input logic mv, input logic fe, input logic [MSGW-1:0] m);
      vec_t v;
      v.vld = vld; v.st = st; v.d = d; v.exp_mv = mv; v.exp_fe = fe; v.exp_msg = m;
      vecs.push_back(v);
   endtask

   task automatic add_frame(input logic [MSGW-1:0] m, input logic fe_first);
      for (int i = 0; i < SLEN; i++)
         add_vec(1'b1, i == 0, byte_of(m, i), i == SLEN - 1, fe_first && i == 0, m);
   endtask

   task automatic send_byte(input logic st, input logic [7:0] d);
      bit done;
      done = 0;
      in_valid = 1'b1; in_start = st; in_data = d;
      for (int n = 0; n < 50 && !done; n++) begin
         @(negedge clk);
         done = in_ready;
         @(posedge clk);
         #1;
      end
      in_valid = 1'b0; in_start = 1'b0;
      chk("send_byte_accepted", done, 1'b1);
   endtask

   task automatic send_range(input logic [MSGW-1:0] m, input int first, input int last);
      for (int i = first; i <= last; i++) send_byte(i == 0, byte_of(m, i));
   endtask

   typedef struct {
      logic       st;
      logic [7:0] d;
   } item_t;
   item_t stream[$];

   function automatic void push_item(input logic st, input logic [7:0] d);
      item_t it;
      it.st = st; it.d = d;
      stream.push_back(it);
   endfunction

   logic [7:0]      cmds[4];
   logic [MSGW-1:0] ma, mb, mc, md, me, mr;
   logic [7:0]      b;
   int              r, n, cycles;
   bit              took;

   initial begin
      #1_000_000;
      $display("FAIL watchdog: time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      cmds = '{CMD_SET_SV, CMD_SUBSCRIBE_SV, CMD_UNSUBSCRIBE_SV, CMD_SET_SV_PERCENT};
      reset_n = 1'b0; in_valid = 1'b0; in_start = 1'b0; in_data = 8'h00; msg_ready = 1'b0;

      // Vector table: stray bytes, basic frame, aborted frame and its restart.
      add_vec(1'b1, 1'b0, 8'hAA, 1'b0, 1'b0, '0);
      add_vec(1'b1, 1'b0, 8'h55, 1'b0, 1'b0, '0);
      add_vec(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, '0);
      add_frame({CMD_SET_SV, 48'h0102_0304_0506, 16'h0010, 32'h0000_007F}, 1'b0);
      add_vec(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, '0);
      add_vec(1'b1, 1'b1, CMD_SUBSCRIBE_SV, 1'b0, 1'b0, '0);
      add_vec(1'b1, 1'b0, 8'h11, 1'b0, 1'b0, '0);
      add_vec(1'b1, 1'b0, 8'h12, 1'b0, 1'b0, '0);
      add_vec(1'b1, 1'b0, 8'h13, 1'b0, 1'b0, '0);
      add_vec(1'b1, 1'b0, 8'h14, 1'b0, 1'b0, '0);
      add_frame({CMD_UNSUBSCRIBE_SV, 48'hA1A2_A3A4_A5A6, 16'hB1B2, 32'hC1C2_C3C4}, 1'b1);
      add_vec(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, '0);

      #3;
      chk("reset_in_ready", in_ready, 1'b0);
      chk("reset_msg_valid", msg_valid, 1'b0);
      chk("reset_fields", out_msg, '0);
      chk("reset_frame_error", frame_error, 1'b0);
      chk("reset_checksum_error", checksum_error, 1'b0);
      #9 reset_n = 1'b1;
      @(posedge clk); #1;

      for (int i = 0; i < vecs.size(); i++) begin
         in_valid = vecs[i].vld; in_start = vecs[i].st; in_data = vecs[i].d; msg_ready = 1'b1;
         @(negedge clk);
         chk("tbl_in_ready", in_ready, 1'b1);
         @(posedge clk); #1;
         chk("tbl_msg_valid", msg_valid, vecs[i].exp_mv);
         chk("tbl_frame_error", frame_error, vecs[i].exp_fe);
         if (vecs[i].exp_mv) chk("tbl_fields", out_msg, vecs[i].exp_msg);
      end
      in_valid = 1'b0; in_start = 1'b0;

      // Backpressure: second frame's final byte waits for the slot.
      msg_ready = 1'b0;
      ma = rand_msg(CMD_SET_SV_PERCENT);
      mb = rand_msg(CMD_SET_SV);
      send_range(ma, 0, SLEN - 1);
      chk("bp_a_valid", msg_valid, 1'b1);
      send_range(mb, 0, SLEN - 2);
      in_valid = 1'b1; in_start = 1'b0; in_data = byte_of(mb, SLEN - 1);
      repeat (3) begin
         @(negedge clk);
         chk("bp_stall_ready", in_ready, 1'b0);
         chk("bp_a_hold", out_msg, ma);
         @(posedge clk); #1;
      end
      msg_ready = 1'b1;
      @(negedge clk);
      chk("bp_release_ready", in_ready, 1'b1);
      @(posedge clk); #1;
      in_valid = 1'b0; msg_ready = 1'b0;
      chk("bp_b_valid", msg_valid, 1'b1);
      chk("bp_b_fields", out_msg, mb);
      msg_ready = 1'b1;
      @(posedge clk); #1;
      chk("bp_drained", msg_valid, 1'b0);

      // Asynchronous reset in the middle of a frame with a full slot.
      msg_ready = 1'b0;
      mc = rand_msg(CMD_SUBSCRIBE_SV);
      md = rand_msg(CMD_UNSUBSCRIBE_SV);
      send_range(mc, 0, SLEN - 1);
      send_range(md, 0, 4);
      chk("pre_rst_valid", msg_valid, 1'b1);
      #2 reset_n = 1'b0;
      #1;
      chk("rst_msg_valid", msg_valid, 1'b0);
      chk("rst_in_ready", in_ready, 1'b0);
      chk("rst_fields", out_msg, '0);
      chk("rst_frame_error", frame_error, 1'b0);
      @(negedge clk);
      #2 reset_n = 1'b1;
      @(posedge clk); #1;
      msg_ready = 1'b1;
      me = rand_msg(CMD_SET_SV);
      send_range(me, 0, SLEN - 1);
      chk("post_rst_valid", msg_valid, 1'b1);
      chk("post_rst_fields", out_msg, me);

`ifdef BSS_CHECKSUM_EN
      mr = rand_msg(CMD_SET_SV_PERCENT);
      send_range(mr, 0, MSG - 1);
      send_byte(1'b0, ~byte_of(mr, MSG));
      chk("cks_err_pulse", checksum_error, 1'b1);
      chk("cks_no_valid", msg_valid, 1'b0);
      @(posedge clk); #1;
      chk("cks_err_single", checksum_error, 1'b0);
`endif

      // Randomised stream: frames, partial frames, strays, bad checksums.
      for (int k = 0; k < 60; k++) begin
         r  = $urandom_range(0, 9);
         mr = rand_msg(cmds[$urandom_range(0, 3)]);
         if (r <= 6 || r == 9) begin
            for (int i = 0; i < SLEN; i++) begin
               b = byte_of(mr, i);
               if (i == MSG && $urandom_range(0, 3) == 0) b = b ^ 8'h5A;
               push_item(i == 0, b);
            end
         end else if (r == 7) begin
            n = $urandom_range(1, MSG - 1);
            for (int i = 0; i < n; i++) push_item(i == 0, byte_of(mr, i));
         end else begin
            n = $urandom_range(1, 2);
            for (int i = 0; i < n; i++) push_item(1'b0, 8'($urandom));
         end
      end
      cycles = 0;
      while (stream.size() > 0 && cycles < 20000) begin
         in_valid  = ($urandom_range(0, 3) != 0);
         in_start  = stream[0].st;
         in_data   = stream[0].d;
         msg_ready = ($urandom_range(0, 2) != 0);
         @(negedge clk);
         took = in_valid && in_ready;
         @(posedge clk); #1;
         if (took) void'(stream.pop_front());
         cycles++;
      end
      chk("random_stream_drained", stream.size(), 0);
      in_valid = 1'b0; in_start = 1'b0; msg_ready = 1'b1;
      repeat (4) @(posedge clk);
      #1;
      chk("final_idle_valid", msg_valid, 1'b0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
